// File: rtl/bg_band_renderer.sv
// Background layer generator: classifies each pixel into sky, tiled band or ground
// and emits {palette, colour} with a fixed three-cycle latency at full throughput.
module bg_band_renderer #(
    parameter int X_BITS       = 10,
    parameter int Y_BITS       = 10,
    parameter int PIX_BITS     = 3,
    parameter int PIX_PER_WORD = 3,
    parameter int ROW_SHIFT    = 4,
    parameter int ADDR_BITS    = 11,
    parameter int PAL_BITS     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pix_valid,
    input  logic [X_BITS-1:0]                x,
    input  logic [Y_BITS-1:0]                y,
    input  logic                             reg_we,
    input  logic [2:0]                       reg_addr,
    input  logic [15:0]                      reg_wdata,
    output logic [ADDR_BITS-1:0]             vram_addr,
    input  logic [PIX_BITS*PIX_PER_WORD-1:0] vram_data,
    output logic [PAL_BITS+3:0]              index_out,
    output logic                             index_valid
);
    localparam int W = PIX_BITS * PIX_PER_WORD;

    // Stream handshake: valid-only, no ready. A pixel presented with pix_valid=1 is
    // always accepted; its result appears with index_valid=1 exactly three edges later.

    logic [PAL_BITS-1:0]  sh_palette,     act_palette,     eff_palette;
    logic [Y_BITS-1:0]    sh_sky_stop,    act_sky_stop,    eff_sky_stop;
    logic [Y_BITS-1:0]    sh_ground_start, act_ground_start, eff_ground_start;
    logic [3:0]           sh_sky_idx,     act_sky_idx,     eff_sky_idx;
    logic [3:0]           sh_ground_idx,  act_ground_idx,  eff_ground_idx;
    logic [ROW_SHIFT-1:0] sh_scroll_word, act_scroll_word, eff_scroll_word;
    logic [2:0]           sh_scroll_sub,  act_scroll_sub,  eff_scroll_sub;

    logic line_start, frame_start;
    assign line_start  = pix_valid && (x == '0);
    assign frame_start = line_start && (y == '0);

    // The frame-start pixel already belongs to the new frame, so it sees the shadow values.
    always_comb begin
        eff_palette      = frame_start ? sh_palette      : act_palette;
        eff_sky_stop     = frame_start ? sh_sky_stop     : act_sky_stop;
        eff_ground_start = frame_start ? sh_ground_start : act_ground_start;
        eff_sky_idx      = frame_start ? sh_sky_idx      : act_sky_idx;
        eff_ground_idx   = frame_start ? sh_ground_idx   : act_ground_idx;
        eff_scroll_word  = frame_start ? sh_scroll_word  : act_scroll_word;
        eff_scroll_sub   = frame_start ? sh_scroll_sub   : act_scroll_sub;
    end

    logic wdata_unused;
    assign wdata_unused = ^reg_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_palette       <= '0;
            sh_sky_stop      <= Y_BITS'(300);
            sh_ground_start  <= Y_BITS'(428);
            sh_sky_idx       <= 4'd5;
            sh_ground_idx    <= 4'd7;
            sh_scroll_word   <= '0;
            sh_scroll_sub    <= '0;
            act_palette      <= '0;
            act_sky_stop     <= Y_BITS'(300);
            act_ground_start <= Y_BITS'(428);
            act_sky_idx      <= 4'd5;
            act_ground_idx   <= 4'd7;
            act_scroll_word  <= '0;
            act_scroll_sub   <= '0;
        end else begin
            if (frame_start) begin
                act_palette      <= sh_palette;
                act_sky_stop     <= sh_sky_stop;
                act_ground_start <= sh_ground_start;
                act_sky_idx      <= sh_sky_idx;
                act_ground_idx   <= sh_ground_idx;
                act_scroll_word  <= sh_scroll_word;
                act_scroll_sub   <= sh_scroll_sub;
            end
            if (reg_we) begin
                case (reg_addr)
                    3'd0: sh_palette      <= reg_wdata[PAL_BITS-1:0];
                    3'd1: sh_sky_stop     <= reg_wdata[Y_BITS-1:0];
                    3'd2: sh_ground_start <= reg_wdata[Y_BITS-1:0];
                    3'd3: sh_sky_idx      <= reg_wdata[3:0];
                    3'd4: sh_ground_idx   <= reg_wdata[3:0];
                    3'd5: sh_scroll_word  <= reg_wdata[ROW_SHIFT-1:0];
                    3'd6: sh_scroll_sub   <= (int'(reg_wdata[2:0]) >= PIX_PER_WORD)
                                             ? 3'(PIX_PER_WORD - 1) : reg_wdata[2:0];
                    default: ;
                endcase
            end
        end
    end

    // word_q/sub_q hold the position of the next pixel; line start overrides them.
    logic [ROW_SHIFT-1:0] word_q, cur_word;
    logic [2:0]           sub_q, cur_sub;
    logic                 last_sub;
    logic                 in_sky, in_ground;
    logic [ADDR_BITS-1:0] row_off, addr_next;

    always_comb begin
        cur_word  = line_start ? eff_scroll_word : word_q;
        cur_sub   = line_start ? eff_scroll_sub  : sub_q;
        last_sub  = (int'(cur_sub) == PIX_PER_WORD - 1);
        in_sky    = (y < eff_sky_stop);
        in_ground = !in_sky && (y >= eff_ground_start);
        row_off   = ADDR_BITS'(y) - ADDR_BITS'(eff_sky_stop);
        addr_next = (row_off << ROW_SHIFT) + ADDR_BITS'(cur_word);
    end

    logic                s1_valid, s1_tile, s2_valid, s2_tile;
    logic [3:0]          s1_flat, s2_flat;
    logic [2:0]          s1_sub, s2_sub;
    logic [PAL_BITS-1:0] s1_pal, s2_pal;
    logic [W-1:0]        tile_shift;
    logic [PIX_BITS-1:0] tile_pix;
    logic [3:0]          colour;

    always_comb begin
        tile_shift = vram_data << (int'(s2_sub) * PIX_BITS);
        tile_pix   = tile_shift[W-1 -: PIX_BITS];
        colour     = s2_tile ? 4'(tile_pix) : s2_flat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q      <= '0;
            sub_q       <= '0;
            vram_addr   <= '0;
            s1_valid    <= 1'b0;
            s1_tile     <= 1'b0;
            s1_flat     <= '0;
            s1_sub      <= '0;
            s1_pal      <= '0;
            s2_valid    <= 1'b0;
            s2_tile     <= 1'b0;
            s2_flat     <= '0;
            s2_sub      <= '0;
            s2_pal      <= '0;
            index_out   <= '0;
            index_valid <= 1'b0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                sub_q     <= last_sub ? 3'd0 : cur_sub + 3'd1;
                word_q    <= last_sub ? cur_word + ROW_SHIFT'(1) : cur_word;
                vram_addr <= addr_next;
                s1_tile   <= !in_sky && !in_ground;
                s1_flat   <= in_sky ? eff_sky_idx : eff_ground_idx;
                s1_sub    <= cur_sub;
                s1_pal    <= eff_palette;
            end
            s2_valid    <= s1_valid;
            s2_tile     <= s1_tile;
            s2_flat     <= s1_flat;
            s2_sub      <= s1_sub;
            s2_pal      <= s1_pal;
            index_valid <= s2_valid;
            if (s2_valid)
                index_out <= {s2_pal, colour};
        end
    end
endmodule

// File: tb/tb_bg_band_renderer.sv
// Bench for bg_band_renderer: directed scenarios plus random lines, checked by a
// position-based reference model feeding a scoreboard of expected outputs.
module tb_bg_band_renderer;
    localparam int PPW   = 3;
    localparam int PB    = 3;
    localparam int W     = 9;
    localparam int RS    = 4;
    localparam int AMASK = 2047;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        reg_we = 1'b0;
    logic [2:0]  reg_addr = '0;
    logic [15:0] reg_wdata = '0;
    logic [10:0] vram_addr;
    logic [8:0]  vram_data = '0;
    logic [8:0]  index_out;
    logic        index_valid;

    bg_band_renderer dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .x(x), .y(y),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .vram_addr(vram_addr), .vram_data(vram_data),
        .index_out(index_out), .index_valid(index_valid)
    );

    // clock / cycle counter / synchronous VRAM
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [8:0] mem [0:2047];
    always @(posedge clk) vram_data <= mem[vram_addr];

    // scoreboard
    logic [8:0]  exp_q[$];
    int          exp_cyc_q[$];
    logic [10:0] addr_q[$];
    int          addr_cyc_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // reference model: registers as plain arrays, scroll as a linear pixel position
    int defs[7] = '{0, 300, 428, 5, 7, 0, 0};
    int sh[7];
    int act[7];
    int base_pos = 0;
    int n_pix = 0;

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            sh[i] = defs[i];
            act[i] = defs[i];
        end
        base_pos = 0;
        n_pix = 0;
    endtask

    task automatic model_pixel(input int px, input int py);
        int pos, word, sub, col, addr;
        if (px == 0 && py == 0)
            for (int i = 0; i < 7; i++) act[i] = sh[i];
        if (px == 0) begin
            base_pos = act[5] * PPW + act[6];
            n_pix = 0;
        end
        pos = base_pos + n_pix;
        n_pix++;
        word = (pos / PPW) % (1 << RS);
        sub = pos % PPW;
        addr = ((py - act[1]) * (1 << RS) + word) & AMASK;
        if (py < act[1]) col = act[3];
        else if (py >= act[2]) col = act[4];
        else col = (int'(mem[addr]) >> (W - PB * (sub + 1))) & ((1 << PB) - 1);
        exp_q.push_back(9'((act[0] << 4) | col));
        exp_cyc_q.push_back(cyc);
        addr_q.push_back(11'(addr));
        addr_cyc_q.push_back(cyc);
    endtask

    task automatic model_write(input int ra, input int wd);
        int v;
        case (ra)
            0: sh[0] = wd & 31;
            1: sh[1] = wd & 1023;
            2: sh[2] = wd & 1023;
            3: sh[3] = wd & 15;
            4: sh[4] = wd & 15;
            5: sh[5] = wd & 15;
            6: begin
                v = wd & 7;
                sh[6] = (v >= PPW) ? PPW - 1 : v;
            end
            default: ;
        endcase
    endtask

    // driver: one clock cycle of stimulus
    task automatic step(input bit pv, input int px, input int py,
                        input bit we, input int ra, input int wd);
        pix_valid = pv;
        x = 10'(px);
        y = 10'(py);
        reg_we = we;
        reg_addr = 3'(ra);
        reg_wdata = 16'(wd);
        if (pv) model_pixel(px, py);
        if (we) model_write(ra, wd);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        reg_we = 1'b0;
    endtask

    task automatic line(input int py, input int x0, input int x1);
        for (int i = x0; i <= x1; i++) step(1, i, py, 0, 0, 0);
    endtask

    task automatic wr(input int ra, input int wd);
        step(0, 0, 0, 1, ra, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        reg_we = 1'b0;
        #1;
        check("rst_index_valid", int'(index_valid), 0);
        check("rst_index_out", int'(index_out), 0);
        check("rst_vram_addr", int'(vram_addr), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        addr_q.delete();
        addr_cyc_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // monitor
    initial begin
        logic [8:0] v;
        int s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (index_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", int'(index_valid), 0);
                    end else begin
                        v = exp_q.pop_front();
                        s = exp_cyc_q.pop_front();
                        check("index_out", int'(index_out), int'(v));
                        check("latency", cyc - s, 3);
                    end
                end else if (exp_q.size() != 0 && exp_cyc_q[0] + 3 <= cyc) begin
                    check("index_valid_missing", int'(index_valid), 1);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
                if (addr_q.size() != 0 && addr_cyc_q[0] + 1 <= cyc) begin
                    check("vram_addr", int'(vram_addr), int'(addr_q[0]));
                    void'(addr_q.pop_front());
                    void'(addr_cyc_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ly, len, ra, wd;
        for (int i = 0; i < 2048; i++) mem[i] = 9'($urandom_range(0, 511));
        mem[0] = 9'b101_010_001;
        mem[1] = 9'b111_000_011;
        model_reset();
        #1;
        do_reset();

        // sky line with defaults
        line(10, 0, 5);
        idle(4);
        // tile band, words 0 and 1
        line(300, 0, 5);
        idle(4);
        // scroll writes stay in shadow until frame start; sub 6 clamps to 2
        wr(6, 6);
        wr(5, 1);
        line(300, 0, 5);
        line(0, 0, 2);
        line(300, 0, 5);
        idle(4);
        // palette written on the frame-start cycle applies only at the next frame
        step(1, 0, 0, 1, 0, 'h1A);
        line(10, 0, 3);
        line(0, 0, 1);
        line(10, 0, 3);
        idle(4);
        // inverted bands: no tile band at all
        wr(1, 500);
        wr(2, 400);
        line(0, 0, 1);
        line(450, 0, 3);
        line(499, 0, 3);
        line(500, 0, 3);
        idle(4);
        // async reset mid-line in the tile band
        do_reset();
        line(310, 0, 7);
        do_reset();
        idle(2);
        line(310, 8, 12);
        idle(4);

        // randomized lines with random gaps and register writes
        for (int l = 0; l < 40; l++) begin
            ly = (l % 8 == 0) ? 0 : $urandom_range(280, 460);
            len = $urandom_range(4, 20);
            for (int px = 0; px < len; px++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if ($urandom_range(0, 5) == 0) begin
                    ra = $urandom_range(0, 7);
                    if (ra == 1) wd = $urandom_range(280, 340);
                    else if (ra == 2) wd = $urandom_range(380, 460);
                    else wd = $urandom_range(0, 65535);
                    step(1, px, ly, 1, ra, wd);
                end else begin
                    step(1, px, ly, 0, 0, 0);
                end
            end
        end
        idle(8);
        check("drain_exp", exp_q.size(), 0);
        check("drain_addr", addr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bg_band_renderer.md
Name: bg_band_renderer

Overview:
- Parametrised background layer generator for the GPU pixel pipeline.
- Each pixel coordinate from the scan generator is classified into one of three bands: sky, tiled band, or ground.
- Sky and ground pixels get a flat palette index. Tiled-band pixels are unpacked from packed background VRAM words, with horizontal scroll applied.
- All band, scroll and palette registers are shadowed and take effect only at frame start, so a frame never tears.

Parameters:
- X_BITS, 10, width of x coordinate
- Y_BITS, 10, width of y coordinate
- PIX_BITS, 3, bits per tile pixel in a VRAM word (1..4)
- PIX_PER_WORD, 3, pixels packed per VRAM word (2..8); VRAM word width W = PIX_BITS*PIX_PER_WORD
- ROW_SHIFT, 4, log2 of VRAM words per tile row; the word counter is ROW_SHIFT bits wide and wraps
- ADDR_BITS, 11, VRAM address width
- PAL_BITS, 5, palette select width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  x/y valid this cycle
- x  in  X_BITS  pixel column
- y  in  Y_BITS  pixel row
- reg_we  in  1  register write strobe
- reg_addr  in  3  register select
- reg_wdata  in  16  register write data
- vram_addr  out  ADDR_BITS  registered VRAM read address
- vram_data  in  W  VRAM read data, valid one cycle after vram_addr
- index_out  out  PAL_BITS+4  {palette, 4-bit colour index}
- index_valid  out  1  index_out valid

Behaviour:
- Reset is asynchronous, active-high. It clears index_out, index_valid, vram_addr, both pipeline valids and the word/sub counters to 0. It loads active and shadow registers to their defaults.
- Register map (writes go to shadow registers only):
  - 0 palette [PAL_BITS-1:0], default 0
  - 1 sky_stop [Y_BITS-1:0], default 300
  - 2 ground_start [Y_BITS-1:0], default 428
  - 3 sky_idx [3:0], default 5
  - 4 ground_idx [3:0], default 7
  - 5 scroll_word [ROW_SHIFT-1:0], default 0
  - 6 scroll_sub [2:0], default 0; values >= PIX_PER_WORD are clamped to PIX_PER_WORD-1 on write
  - 7 reserved; writes are ignored
- Frame start is a cycle with pix_valid=1, x=0, y=0. At that edge all shadow registers are copied to active. A write in the same cycle lands in the shadow only; the active copy takes the pre-write shadow value.
- Band classification, using active registers:
  - y < sky_stop: sky
  - else y >= ground_start: ground
  - else: tile band
  - If sky_stop >= ground_start, there is no tile band.
- Scroll counters advance only on pix_valid:
  - Line start (pix_valid, x=0): word <= scroll_word, sub <= scroll_sub; the frame-start copy applies first.
  - Otherwise, on each valid pixel, sub increments. At PIX_PER_WORD-1 it wraps to 0 and word increments mod 2^ROW_SHIFT.
  - The counters advance in all bands.
- Address: vram_addr = ((y - sky_stop) << ROW_SHIFT) + word, truncated to ADDR_BITS, using the current pixel's word value. It is registered at stage 1 and holds its value when pix_valid=0.
- Pipeline, for a pixel sampled at edge N:
  - Stage 1 (edge N+1): register vram_addr, band, sub, valid.
  - Stage 2 (edge N+2): pass band, sub, valid, aligned with vram_data.
  - Output (edge N+3): register index_out and index_valid.
  - Fixed latency is 3 cycles, full throughput, no stalls.
- Tile pixel select is MSB-first: sub s takes vram_data[W-1-s*PIX_BITS -: PIX_BITS], zero-extended to 4 bits.
- index_out = {palette_active, colour}, where colour is sky_idx, ground_idx or the tile pixel. The palette is the value active when the pixel was sampled.
- When pix_valid=0, index_valid goes low after 3 cycles and index_out holds its last value.
- Reset mid-line: the output is invalid until 3 cycles after the first valid pixel following reset release. The counters restart at 0 until the next line start.

Test Plan:
- After reset, feed a y=10 line at x=0..5 with defaults -> index_valid rises at the 3rd edge; index_out=9'h005 for every pixel.
- y=300, VRAM word 0 = 9'b101_010_001, word 1 = 9'b111_000_011, defaults, x=0..5 -> colours 5,2,1,7,0,3; vram_addr 0,0,0,1,1,1; latency 3.
- Write scroll_sub=2 and scroll_word=1 mid-frame -> no change until frame start. At the next y=300 line: first colour from word 1 sub 2 (3), then word 2 sub 0. Also write scroll_sub=6 -> it reads back as effective clamp 2.
- Write palette=5'h1A in the same cycle as frame start -> that frame uses the old palette. The next frame start applies 1A, giving index_out=9'h1A5 in the sky.
- Set sky_stop=500, ground_start=400 -> rows 0..499 are sky and rows 500+ are ground; no VRAM-derived colour appears.
- Assert rst for 1 cycle mid-stream at tile band x=7 -> outputs and index_valid clear immediately (async). The next valid pixel produces output 3 cycles later.
